// File: rtl/fewcore_pkg.sv
// fewcore_pkg: shared widths and the data-memory responder FSM state type
package fewcore_pkg;
  localparam int XLEN = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array_be.sv
// mem_array_be: synchronous DEPTH_WORDS x XLEN word array, one port, per-byte write enables, no reset
//   clk   rising-edge clock
//   en    access strobe; read data is captured (pre-write value) and enabled bytes are written
//   we    byte write enables, lane i is wdata[8i+7:8i]
//   addr  word index
//   wdata write data
//   rdata registered read data, holds between accesses
module mem_array_be
  import fewcore_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            en,
  input  logic [BE_W-1:0] we,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < BE_W; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency load/store responder over valid/ready request and response channels
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake; one request outstanding at a time
//   req_write             1 = store, 0 = load
//   req_addr, req_wdata   byte address and store data
//   req_be                store byte enables
//   rsp_valid/rsp_ready   response handshake, held under back-pressure
//   rsp_rdata             load data, 0 for stores and errors
//   rsp_err               misaligned or out-of-range access
module data_mem_responder
  import fewcore_pkg::*;
#(
  parameter int              DEPTH_WORDS = 256,
  parameter int              LATENCY     = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, nxt;
  logic [3:0] cnt;
  logic wr_q, ld_q, acc, fire, err;
  logic [XLEN-1:0] addr_q, wdata_q, off, mem_rdata;
  logic [BE_W-1:0] be_q;
  // addresses below BASE_ADDR wrap to huge offsets and fail the range check
  assign off  = addr_q - BASE_ADDR;
  assign err  = (|addr_q[1:0]) || ((off >> 2) >= XLEN'(DEPTH_WORDS));
  assign acc  = req_valid && req_ready;
  // cnt starts at LATENCY-1, so the access lands on edge N+LATENCY
  assign fire = (state == WAIT) && (cnt == '0);
  // the array's read register holds its value; ld_q gates it to 0 for stores, errors and reset
  assign rsp_rdata = ld_q ? mem_rdata : '0;
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (acc ? WAIT : IDLE) :
          (state == WAIT) ? (fire ? RESP : WAIT) :
          (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state     <= nxt;
      req_ready <= (nxt == IDLE);
      if (acc) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        ld_q      <= !wr_q && !err;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        ld_q      <= 1'b0;
      end
    end
  mem_array_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk   (clk),
    .en    (fire && !err),
    .we    (wr_q ? be_q : '0),
    .addr  (off[AW+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );
endmodule
